// File: rtl/picorv32_pcpi_mul_pkg.sv
// Shared types and encodings for the iterative PCPI multiplier.
package picorv32_pcpi_mul_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} mul_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // MUL returns the low word, every MULH* variant the high word.
  function automatic logic [31:0] mul_result(input logic low_word, input logic [63:0] prod);
    return low_word ? prod[31:0] : prod[63:32];
  endfunction

endpackage

// File: rtl/picorv32_mul_step.sv
// One iteration of the shift-add multiplier: acc + mcand * STEP_BITS-wide digit, mod 2^64.
module picorv32_mul_step #(
  parameter int unsigned STEP_BITS = 4
) (
  input  logic [63:0]          acc,
  input  logic [63:0]          mcand,
  input  logic [STEP_BITS-1:0] digit,
  output logic [63:0]          acc_next
);

  assign acc_next = acc + mcand * 64'(digit);

endmodule

// File: rtl/picorv32_pcpi_iter_mul.sv
// Iterative MUL/MULH/MULHSU/MULHU PCPI co-processor retiring STEP_BITS multiplier bits per
// cycle, with an optional one-entry product cache for MULH*/MUL pairs.
module picorv32_pcpi_iter_mul
  import picorv32_pcpi_mul_pkg::*;
#(
  parameter int unsigned STEP_BITS    = 4,
  parameter int unsigned RESULT_CACHE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int unsigned N = 64 / STEP_BITS;

  mul_state_e  state_q, state_d;
  logic        valid_mul_q;
  logic [63:0] acc_q, mcand_q, mplier_q;
  logic [6:0]  cnt_q;
  logic [31:0] rd_q;

  logic [2:0]  funct3;
  logic        valid_mul, start, is_mul, rs1_signed, rs2_signed;
  logic [63:0] rs1_ext, rs2_ext, acc_next, cache_prod;
  logic        cache_hit, calc_done;
  logic        unused_insn;

  assign funct3     = pcpi_insn[14:12];
  // funct3[2] set selects div/rem, which this unit leaves to another co-processor.
  assign valid_mul  = pcpi_valid && (pcpi_insn[6:0] == OPCODE_OP) &&
                      (pcpi_insn[31:25] == FUNCT7_MULDIV) && !funct3[2];
  assign start      = valid_mul && !valid_mul_q;
  assign is_mul     = (funct3 == F3_MUL);
  assign rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign rs2_signed = (funct3 == F3_MULH);
  assign rs1_ext    = {{32{rs1_signed & pcpi_rs1[31]}}, pcpi_rs1};
  assign rs2_ext    = {{32{rs2_signed & pcpi_rs2[31]}}, pcpi_rs2};
  assign calc_done  = (state_q == StCalc) && valid_mul && (cnt_q == 7'd0);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  picorv32_mul_step #(
    .STEP_BITS(STEP_BITS)
  ) u_step (
    .acc     (acc_q),
    .mcand   (mcand_q),
    .digit   (mplier_q[STEP_BITS-1:0]),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = cache_hit ? StDone : StCalc;
      StCalc: begin
        if (!valid_mul) begin
          state_d = StIdle;
        end else if (cnt_q == 7'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pcpi_wait  = (state_q == StCalc);
    pcpi_ready = (state_q == StDone);
    pcpi_wr    = pcpi_ready;
  end

  assign pcpi_rd = rd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_mul_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
    end else begin
      valid_mul_q <= valid_mul;
      if (state_q == StIdle && start && !cache_hit) begin
        acc_q    <= '0;
        mcand_q  <= rs1_ext;
        mplier_q <= rs2_ext;
        cnt_q    <= 7'(N - 1);
      end else if (state_q == StCalc) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << STEP_BITS;
        mplier_q <= mplier_q >> STEP_BITS;
        cnt_q    <= cnt_q - 7'd1;
      end
      if (state_q == StIdle && start && cache_hit) begin
        rd_q <= mul_result(is_mul, cache_prod);
      end else if (calc_done) begin
        rd_q <= mul_result(is_mul, acc_next);
      end
    end
  end

  if (RESULT_CACHE != 0) begin : g_cache
    logic        c_valid_q, c_s1_q, c_s2_q;
    logic [31:0] c_rs1_q, c_rs2_q;
    logic [63:0] c_prod_q;

    // The core holds insn and operands while valid is high, so the live bus is the op's key.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        c_valid_q <= 1'b0;
        c_s1_q    <= 1'b0;
        c_s2_q    <= 1'b0;
        c_rs1_q   <= '0;
        c_rs2_q   <= '0;
        c_prod_q  <= '0;
      end else if (calc_done) begin
        c_valid_q <= 1'b1;
        c_s1_q    <= rs1_signed;
        c_s2_q    <= rs2_signed;
        c_rs1_q   <= pcpi_rs1;
        c_rs2_q   <= pcpi_rs2;
        c_prod_q  <= acc_next;
      end
    end

    // The low word of the product does not depend on operand signedness.
    assign cache_hit  = c_valid_q && (c_rs1_q == pcpi_rs1) && (c_rs2_q == pcpi_rs2) &&
                        (is_mul || ((c_s1_q == rs1_signed) && (c_s2_q == rs2_signed)));
    assign cache_prod = c_prod_q;
  end else begin : g_no_cache
    assign cache_hit  = 1'b0;
    assign cache_prod = '0;
  end

endmodule

// File: doc/picorv32_pcpi_iter_mul.md
# picorv32_pcpi_iter_mul

Iterative, area-configurable multiplier co-processor on the PicoRV32 PCPI bus, executing MUL, MULH, MULHSU and MULHU. It processes STEP_BITS multiplier bits per cycle, so one parameter trades area against latency. It drives pcpi_wait so the core's PCPI timeout does not fire during long multiplies. A one-entry result cache returns the second half of a MULH*/MUL pair in one cycle.

## Interface
- STEP_BITS, 4: multiplier bits retired per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Iteration count N = 64/STEP_BITS.
- RESULT_CACHE, 1: 1 enables the one-entry product cache; 0 removes it, so every op takes the full latency.
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pcpi_valid  in  1  instruction offered; held by the core until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  result write enable; equals pcpi_ready
- pcpi_rd  out  32  result; registered
- pcpi_wait  out  1  high while computing
- pcpi_ready  out  1  single-cycle completion pulse

## Operation
- **Decode (combinational).** An instruction is a valid mul when pcpi_valid && opcode[6:0]==7'b0110011 && funct7==7'b0000001 && funct3 is in 000..011.
  - funct3 1xx (div/rem) is ignored.
  - Non-matching instructions are ignored.
- **Start condition.** start = valid_mul && !valid_mul_q, a rising edge of the decoded valid. A held pcpi_valid therefore never restarts the unit after pcpi_ready.
- **Operand extension.**
  - rs1 is sign-extended to 64 bits for MULH and MULHSU, zero-extended otherwise.
  - rs2 is sign-extended to 64 bits for MULH only, zero-extended otherwise.
  - The product is computed mod 2^64 from these extended operands.
- **FSM states.** IDLE, CALC, DONE.
  - IDLE + start + cache hit → DONE; the result comes from the cache.
  - IDLE + start + cache miss → CALC. Latch the extended operands, clear the accumulator, set the iteration counter to N-1.
  - CALC, each cycle: acc += mcand * mplier[STEP_BITS-1:0]; mcand <<= STEP_BITS; mplier >>= STEP_BITS; counter decrements.
  - CALC with counter==0 → DONE; write the cache.
  - CALC with !valid_mul → IDLE (abort). No ready pulse; the cache is not written.
  - DONE → IDLE, unconditionally.
- **Result select.** pcpi_rd is the low word of the product for MUL and the high word for MULH*. It is registered on the transition into DONE and holds its value until the next transition into DONE.
- **Cache contents.** rs1, rs2, rs1_signed, rs2_signed, the 64-bit product and a valid bit.
- **Cache hit rule.**
  - For MULH*: the operands and both signedness flags must match.
  - For MUL: matching operands are enough, because the low word is independent of signedness.
- **Cache update.** The cache is written only on normal CALC completion.

## Timing
- Cycle 0 is the first cycle in which valid_mul is high.
- Cache miss: CALC occupies cycles 1..N; pcpi_ready/pcpi_wr are high in cycle N+1 only. Latency is N+1 (17 for STEP_BITS=4).
- Cache hit: pcpi_ready is high in cycle 1.
- pcpi_wait = (state==CALC). It is never high in the same cycle as pcpi_ready.
- Reset values: pcpi_ready, pcpi_wr and pcpi_wait are 0; pcpi_rd is 0; state is IDLE; cache valid is 0; valid_mul_q is 0.
- Async reset mid-CALC: outputs drop immediately and the cache is invalidated.
- If valid drops and re-rises within one cycle during DONE, this counts as a new start from IDLE.

## Structure
- Package picorv32_pcpi_mul_pkg holds:
  - the state enum;
  - the opcode and funct7 constants;
  - funct3 codes F3_MUL/F3_MULH/F3_MULHSU/F3_MULHU.
- Sub-module picorv32_mul_step: a combinational 64-bit by STEP_BITS-bit partial product plus accumulate, one instance.
- Cache logic is generate-guarded by RESULT_CACHE.

## Test plan
- **Basic MUL, miss latency.** STEP_BITS=4, MUL rs1=7, rs2=0xFFFFFFFD → pcpi_rd=0xFFFFFFEB. pcpi_wait is high for cycles 1..16 and pcpi_ready/pcpi_wr pulse only in cycle 17.
- **Signedness.** Operands 0x80000000×0x80000000: MULH → 0x40000000, MULHU → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- **Cache hit and signed miss.** MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE at full latency. Then MUL with the same operands → 0x00000001 with ready in cycle 1. Then MULH with the same operands → 0x00000000 at full latency (signedness miss).
- **Abort.** Drop pcpi_valid in cycle 5 of CALC → IDLE next cycle and no ready pulse. Then MUL 2×3 → 6 at full latency, so the aborted op left no cache entry.
- **Async reset and parameter sweep.** Assert resetn low mid-CALC → ready/wr/wait are 0 immediately. After release, repeat the previously cached op → full latency. Repeat the signedness vectors plus 1000 random vectors for STEP_BITS=1 (latency 65) and STEP_BITS=64 (latency 2).
- **Ignored instructions.** ADD (funct7 0000000) and DIV (funct7 0000001, funct3 100) → no ready pulse and pcpi_wait stays 0 for 100 cycles.
